// File: rtl/shift_rotate_pkg.sv
// Shared definitions for the shift/rotate datapath: operation codes, the
// serial unit's FSM state encoding and a small helper. Also used by the
// combinational barrel shifter so both units agree on opcode meaning.
package shift_rotate_pkg;

  typedef enum logic [2:0] {
    OP_LSL = 3'd0,
    OP_LSR = 3'd1,
    OP_ASL = 3'd2,
    OP_ASR = 3'd3,
    OP_ROL = 3'd4,
    OP_ROR = 3'd5,
    OP_RLC = 3'd6,
    OP_RRC = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Only the rotate-through-carry ops carry a meaningful carry bit.
  function automatic logic is_carry_op(op_e op);
    return (op == OP_RLC) || (op == OP_RRC);
  endfunction

endpackage

// File: rtl/shift_rotate_step.sv
// One-bit shift/rotate step on the {carry,data} register.
// Ports:
//   op         operation code
//   carry      current carry bit
//   data       current data word
//   next_carry carry after one step (0 for non-carry ops)
//   next_data  data after one step
module shift_rotate_step
  import shift_rotate_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  op_e                   op,
  input  logic                  carry,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  next_carry,
  output logic [DATA_WIDTH-1:0] next_data
);

  always_comb begin
    next_carry = 1'b0;
    next_data  = data;
    case (op)
      OP_LSL, OP_ASL: next_data = {data[DATA_WIDTH-2:0], 1'b0};
      OP_LSR:         next_data = {1'b0, data[DATA_WIDTH-1:1]};
      OP_ASR:         next_data = {data[DATA_WIDTH-1], data[DATA_WIDTH-1:1]};
      OP_ROL:         next_data = {data[DATA_WIDTH-2:0], data[DATA_WIDTH-1]};
      OP_ROR:         next_data = {data[0], data[DATA_WIDTH-1:1]};
      OP_RLC: begin
        next_data  = {data[DATA_WIDTH-2:0], carry};
        next_carry = data[DATA_WIDTH-1];
      end
      OP_RRC: begin
        next_data  = {carry, data[DATA_WIDTH-1:1]};
        next_carry = data[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/serial_shift_rotate_unit.sv
// Serial shift/rotate unit: performs one single-bit step per clock on a
// captured {carry,data} register, producing the same result as the
// combinational barrel shifter after L+1 cycles.
// Ports:
//   Clock_In, Reset_n_In   clock (rising edge), async active-low reset
//   Enable_In              output enable; 0 tristates data/carry outputs
//   Start_In               request, accepted only in IDLE
//   Shift_Operation_In     opcode (see shift_rotate_pkg::op_e)
//   Shift_Bits_Length_In   number of positions, 0..DATA_WIDTH-1
//   Carry_In, Data_In      operands
//   Busy_Out               request in progress (SHIFT or DONE)
//   Done_Out               one-cycle result-valid pulse
//   Shifted_Data_Out       result, held until next acceptance
//   Carry_Out              result carry, held until next acceptance
module serial_shift_rotate_unit
  import shift_rotate_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  localparam int LEN_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                  Clock_In,
  input  logic                  Reset_n_In,
  input  logic                  Enable_In,
  input  logic                  Start_In,
  input  logic [2:0]            Shift_Operation_In,
  input  logic [LEN_WIDTH-1:0]  Shift_Bits_Length_In,
  input  logic                  Carry_In,
  input  logic [DATA_WIDTH-1:0] Data_In,
  output logic                  Busy_Out,
  output logic                  Done_Out,
  output logic [DATA_WIDTH-1:0] Shifted_Data_Out,
  output logic                  Carry_Out
);

  state_e                state_q, state_d;
  op_e                   op_q, op_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  carry_q, carry_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;

  logic [DATA_WIDTH-1:0] step_data;
  logic                  step_carry;
  op_e                   op_in;

  assign op_in = op_e'(Shift_Operation_In);

  shift_rotate_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
    .op         (op_q),
    .carry      (carry_q),
    .data       (data_q),
    .next_carry (step_carry),
    .next_data  (step_data)
  );

  always_ff @(posedge Clock_In or negedge Reset_n_In) begin
    if (!Reset_n_In) begin
      state_q <= ST_IDLE;
      op_q    <= OP_LSL;
      data_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (Start_In) begin
          op_d    = op_in;
          data_d  = Data_In;
          // Carry is forced to 0 for non-carry ops so Carry_Out reads 0
          // for them even at length 0.
          carry_d = is_carry_op(op_in) & Carry_In;
          cnt_d   = Shift_Bits_Length_In;
          state_d = (Shift_Bits_Length_In == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        data_d  = step_data;
        carry_d = step_carry;
        cnt_d   = cnt_q - LEN_WIDTH'(1);
        if (cnt_q == LEN_WIDTH'(1)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign Busy_Out         = (state_q != ST_IDLE);
  assign Done_Out         = (state_q == ST_DONE);
  assign Shifted_Data_Out = Enable_In ? data_q : {DATA_WIDTH{1'bz}};
  assign Carry_Out        = Enable_In ? carry_q : 1'bz;

endmodule
